// File: rtl/fifo_gen2_if.sv
// Handshake and status bundle for fifo_gen2: the producer/consumer side drives the master
// modport, the FIFO implements the slave modport.
interface fifo_gen2_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              wen;
  logic [DATA_W-1:0] wdata;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output wen, wdata, ren, clr_err,
    input  rdata, rvalid, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

  modport slave (
    input  wen, wdata, ren, clr_err,
    output rdata, rvalid, empty, full, almost_empty, almost_full, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_gen2.sv
// Parametrised single-clock FIFO with level, threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module fifo_gen2 #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = 14,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_gen2_if.slave  bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_TH);
  localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              empty, full, rd_acc, wr_acc;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LVL_FULL);
  assign rd_acc = bus.ren && !empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign wr_acc = bus.wen && (!full || rd_acc);

  always_comb begin
    level_d = level_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Setting wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.wen && !wr_acc) ovf_d = 1'b1;
    if (bus.ren && empty)   udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.wdata;
  end

`ifdef FIFO_FWFT_EN
  assign bus.rdata  = empty ? '0 : mem[rd_ptr_q];
  assign bus.rvalid = !empty;
`else
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem[rd_ptr_q];
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`endif

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (level_q <= LVL_AEMPTY);
  assign bus.almost_full  = (level_q >= LVL_AFULL);
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_gen2.sv
// Scoreboard bench for fifo_gen2: accepted writes are queued, reads pop and compare,
// and all status outputs are checked against a reference model after every edge.
module tb_fifo_gen2;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF_TH  = 14;
  localparam int unsigned AE_TH  = 2;

  logic clk = 1'b0;
  logic reset;

  fifo_gen2_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_gen2 #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] m_rdata;
  logic              m_rvalid, m_ovf, m_udf;
  int                n_vec = 0;
  int                n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int lvl;
    lvl = sb.size();
    check("level", 32'(bus.level), 32'(lvl));
    check("empty", 32'(bus.empty), 32'(lvl == 0));
    check("full", 32'(bus.full), 32'(lvl == DEPTH));
    check("almost_empty", 32'(bus.almost_empty), 32'(lvl <= AE_TH));
    check("almost_full", 32'(bus.almost_full), 32'(lvl >= AF_TH));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("underflow", 32'(bus.underflow), 32'(m_udf));
`ifdef FIFO_FWFT_EN
    check("rvalid", 32'(bus.rvalid), 32'(lvl != 0));
    check("rdata", 32'(bus.rdata), (lvl != 0) ? 32'(sb[0]) : 32'd0);
`else
    check("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
    check("rdata", 32'(bus.rdata), 32'(m_rdata));
`endif
  endtask

  task automatic model_reset();
    sb.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r,
                       input logic c);
    logic rd_acc, wr_acc;
    @(negedge clk);
    bus.wen     = w;
    bus.wdata   = d;
    bus.ren     = r;
    bus.clr_err = c;
    rd_acc   = r && (sb.size() != 0);
    wr_acc   = w && ((sb.size() != DEPTH) || rd_acc);
    m_rvalid = 1'b0;
    if (rd_acc) begin
      m_rdata  = sb.pop_front();
      m_rvalid = 1'b1;
    end
    if (wr_acc) sb.push_back(d);
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (w && !wr_acc) m_ovf = 1'b1;
    if (r && !rd_acc) m_udf = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    bus.wen = 1'b0; bus.wdata = '0; bus.ren = 1'b0; bus.clr_err = 1'b0;
    reset = 1'b1;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Fill past full: the 17th write (0xA) must be dropped.
    for (int i = 0; i < 16; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Underflow, clear, and clear colliding with a new underflow.
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Full with simultaneous read/write across pointer wrap.
    for (int i = 0; i < 16; i++) cycle(1'b1, DATA_W'(i + 3), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, DATA_W'(i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream, between clock edges.
    for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'(i + 9), 1'b0, 1'b0);
    @(negedge clk);
    bus.wen = 1'b0; bus.ren = 1'b0; bus.clr_err = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    #1 check_outputs();
    #1 reset = 1'b0;
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Single word into empty FIFO, then popped.
    cycle(1'b1, 4'h7, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Random traffic with occasional error clears.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
